sync_polarity_norm: RTL

//  Parametrised successor to the per-sync polarity fixer. Normalises NCH video sync inputs
//  (HS, VS, CSYNC, ...) to one selected output polarity, all in the video clock domain.

---
 rtl/sync_polarity_norm.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sync_polarity_norm.sv
// sync_polarity_norm
// Normalises NCH video sync inputs (HS, VS, CSYNC, ...) to a single output
// polarity. Each channel times its high and low intervals, infers which level
// is the active pulse, and flips its inversion only after LOCK_CNT agreeing
// decisions. Channels share nothing but the clock and reset.
//
// The low interval is compared against the stored high interval in the same
// cycle as the rising edge that closes it, so only the high interval needs a
// holding register.

module sync_polarity_norm #(
    parameter int NCH            = 2,
    parameter int CNT_W          = 16,
    parameter int LOCK_CNT       = 2,
    parameter int OUT_ACTIVE_LOW = 0
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [NCH-1:0] sync_in,
    output logic [NCH-1:0] sync_out,
    output logic [NCH-1:0] pol,
    output logic [NCH-1:0] locked,
    output logic [NCH-1:0] stall
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [3:0]       LOCK_V  = 4'(LOCK_CNT);
    localparam logic             OAL_BIT = 1'(OUT_ACTIVE_LOW);

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch

        logic             s1_r;
        logic             s2_r;
        logic [CNT_W-1:0] cnt_r;
        logic [CNT_W-1:0] high_len_r;
        logic             seen_edge_r;
        logic             have_hi_r;
        logic [3:0]       agree_r;
        logic             pol_r;
        logic             locked_r;
        logic             stall_r;
        logic             out_r;

        logic             rise_s;
        logic             fall_s;
        logic             sat_s;
        logic             decide_s;
        logic             cand_s;
        logic [3:0]       agree_inc_s;

        // Edge detection, saturation and the polarity candidate for this cycle
        always_comb begin
            rise_s      = s1_r & ~s2_r;
            fall_s      = ~s1_r & s2_r;
            sat_s       = (cnt_r == CNT_MAX);
            // A decision needs a bounded low interval (armed) and a stored high interval
            decide_s    = rise_s & seen_edge_r & have_hi_r;
            // Longer high than low means the short low is the pulse: active-low input
            cand_s      = (high_len_r > cnt_r);
            agree_inc_s = agree_r + 4'd1;
        end

        // Synchroniser, interval timing, hysteresis and the registered output
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                s1_r        <= 1'b0;
                s2_r        <= 1'b0;
                cnt_r       <= {CNT_W{1'b0}};
                high_len_r  <= {CNT_W{1'b0}};
                seen_edge_r <= 1'b0;
                have_hi_r   <= 1'b0;
                agree_r     <= 4'd0;
                pol_r       <= 1'b0;
                locked_r    <= 1'b0;
                stall_r     <= 1'b0;
                out_r       <= OAL_BIT;
            end else begin
                s1_r  <= sync_in[ch];
                s2_r  <= s1_r;
                out_r <= s2_r ^ pol_r ^ OAL_BIT;

                if (rise_s || fall_s) begin
                    cnt_r       <= {CNT_W{1'b0}};
                    seen_edge_r <= 1'b1;
                    stall_r     <= 1'b0;
                    // The first edge after reset or stall only arms the timer
                    if (seen_edge_r && fall_s) begin
                        high_len_r <= cnt_r;
                        have_hi_r  <= 1'b1;
                    end
                    if (decide_s) begin
                        if (cand_s == pol_r) begin
                            agree_r  <= 4'd0;
                            locked_r <= 1'b1;
                        end else begin
                            locked_r <= 1'b0;
                            if (agree_inc_s == LOCK_V) begin
                                pol_r   <= cand_s;
                                agree_r <= 4'd0;
                            end else begin
                                agree_r <= agree_inc_s;
                            end
                        end
                    end
                end else if (sat_s) begin
                    // No edge for the full counter range: drop all measurements, keep pol
                    stall_r     <= 1'b1;
                    locked_r    <= 1'b0;
                    seen_edge_r <= 1'b0;
                    have_hi_r   <= 1'b0;
                    agree_r     <= 4'd0;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end
        end

        assign sync_out[ch] = out_r;
        assign pol[ch]      = pol_r;
        assign locked[ch]   = locked_r;
        assign stall[ch]    = stall_r;
    end

endmodule
